// File: rtl/mux_rr_arbiter.sv
// Purpose: two-source packet-aware round-robin arbiter feeding mux_struct; registered beat + sel.
// Latency: 1 cycle from accepted source beat to out_*/sel.
// Backpressure: readies = space (!out_valid || out_ready) for the granted source only; output holds while stalled.
module mux_rr_arbiter #(
    parameter int size  = 8,
    parameter int cnt_w = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [size-1:0]  a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [size-1:0]  b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [size-1:0]  out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic [cnt_w-1:0] a_count,
    output logic [cnt_w-1:0] b_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t state;
    logic   ptr;        // 0 = a has priority on contention, 1 = b
    logic   space;
    logic   grant_a;
    logic   grant_b;
    logic   acc_a;
    logic   acc_b;

    assign space = !out_valid || out_ready;

    // Pick the source that owns the output this cycle: locked source, else round-robin among valids.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            LOCK_A: grant_a = 1'b1;
            LOCK_B: grant_b = 1'b1;
            default: begin
                if (a_valid && (!b_valid || !ptr)) begin
                    grant_a = 1'b1;
                end else if (b_valid) begin
                    grant_b = 1'b1;
                end
            end
        endcase
    end

    // Readies are also masked by reset so nothing is offered while the block is held in reset.
    assign a_ready = rst_n && space && grant_a;
    assign b_ready = rst_n && space && grant_b;
    assign acc_a   = a_valid && a_ready;
    assign acc_b   = b_valid && b_ready;

    // Packet lock FSM and round-robin pointer; the pointer flips only at end of packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 1'b0;
        end else begin
            if (acc_a) begin
                if (a_last) begin
                    state <= IDLE;
                    ptr   <= 1'b1;
                end else begin
                    state <= LOCK_A;
                end
            end else if (acc_b) begin
                if (b_last) begin
                    state <= IDLE;
                    ptr   <= 1'b0;
                end else begin
                    state <= LOCK_B;
                end
            end
        end
    end

    // Single output register: data, last and sel always load together so sel matches out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            sel       <= 1'b0;
        end else begin
            if (acc_a) begin
                out_valid <= 1'b1;
                out_data  <= a_data;
                out_last  <= a_last;
                sel       <= 1'b0;
            end else if (acc_b) begin
                out_valid <= 1'b1;
                out_data  <= b_data;
                out_last  <= b_last;
                sel       <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Saturating accepted-beat counters for debug visibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (acc_a && (a_count != {cnt_w{1'b1}})) begin
                a_count <= a_count + 1'b1;
            end
            if (acc_b && (b_count != {cnt_w{1'b1}})) begin
                b_count <= b_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Purpose: directed self-checking bench for mux_rr_arbiter (default widths plus a cnt_w=2 instance).
// Latency: outputs sampled 1 time unit after the rising edge; readies sampled 1 unit after inputs change.
// Backpressure: out_ready driven directly by the bench.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, a_last, b_valid, b_last, out_ready;
    logic [7:0] a_data, b_data;

    logic        a_ready, b_ready, out_valid, out_last, sel;
    logic [7:0]  out_data;
    logic [15:0] a_count, b_count;

    logic       s_a_ready, s_b_ready, s_out_valid, s_out_last, s_sel;
    logic [7:0] s_out_data;
    logic [1:0] s_a_count, s_b_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.size(8), .cnt_w(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .sel(sel), .a_count(a_count), .b_count(b_count)
    );

    mux_rr_arbiter #(.size(8), .cnt_w(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(s_a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(s_b_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last), .out_ready(out_ready),
        .sel(s_sel), .a_count(s_a_count), .b_count(s_b_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [7:0] ad, input logic al,
                         input logic bv, input logic [7:0] bd, input logic bl);
        a_valid = av; a_data = ad; a_last = al;
        b_valid = bv; b_data = bd; b_last = bl;
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        #1;
    endtask

    logic [7:0] exp_d [4];
    logic       exp_s [4];
    logic [1:0] exp_sat [5];

    initial begin
        exp_d = '{8'h11, 8'h22, 8'h11, 8'h22};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // ---- reset with valids high ----
        rst_n = 1'b0; out_ready = 1'b1;
        drive(1, 8'hAA, 1, 1, 8'hBB, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_last",  out_last,  0);
        check("rst_sel",       sel,       0);
        check("rst_a_ready",   a_ready,   0);
        check("rst_b_ready",   b_ready,   0);
        check("rst_a_count",   a_count,   0);
        check("rst_b_count",   b_count,   0);
        tick();
        check("rst_hold_valid", out_valid, 0);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        tick(); tick();
        check("idle_out_valid", out_valid, 0);
        check("idle_a_ready",   a_ready,   0);
        check("idle_b_ready",   b_ready,   0);

        // ---- single-beat contention alternates a,b,a,b ----
        drive(1, 8'h11, 1, 1, 8'h22, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr_data%0d", i), out_data, exp_d[i]);
            check($sformatf("rr_sel%0d", i),  sel,      exp_s[i]);
        end
        drive(0, 0, 0, 0, 0, 0);
        check("rr_a_count", a_count, 2);
        check("rr_b_count", b_count, 2);

        // ---- packet lock: a sends 3 beats, b waits ----
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'hA1 + 8'(i), (i == 2), 1, 8'hB1, 1);
            check($sformatf("lock_b_ready%0d", i), b_ready, 0);
            check($sformatf("lock_a_ready%0d", i), a_ready, 1);
            tick();
            check($sformatf("lock_data%0d", i), out_data, 8'hA1 + 8'(i));
            check($sformatf("lock_last%0d", i), out_last, (i == 2));
        end
        drive(1, 8'hA4, 1, 1, 8'hB1, 1);
        check("lock_next_b_ready", b_ready, 1);
        check("lock_next_a_ready", a_ready, 0);
        tick();
        check("lock_next_data", out_data, 8'hB1);
        check("lock_next_sel",  sel,      1);
        drive(0, 0, 0, 0, 0, 0);
        check("lock_a_count", a_count, 5);
        check("lock_b_count", b_count, 3);

        // ---- backpressure ----
        drive(1, 8'h33, 1, 0, 0, 0);
        tick();
        check("bp_load_data", out_data, 8'h33);
        out_ready = 1'b0;
        drive(1, 8'h44, 1, 1, 8'h55, 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_a_ready%0d", i), a_ready, 0);
            check($sformatf("bp_b_ready%0d", i), b_ready, 0);
            tick();
            check($sformatf("bp_valid%0d", i), out_valid, 1);
            check($sformatf("bp_data%0d", i),  out_data,  8'h33);
            check($sformatf("bp_last%0d", i),  out_last,  1);
            check($sformatf("bp_sel%0d", i),   sel,       0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_b_ready", b_ready, 1);
        check("bp_release_a_ready", a_ready, 0);
        tick();
        check("bp_release_data", out_data, 8'h55);
        check("bp_release_sel",  sel,      1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_data",  out_data,  8'h55);
        check("drain_sel",   sel,       1);

        // ---- reset mid-packet ----
        drive(1, 8'h61, 0, 0, 0, 0);
        tick();
        check("mid_valid_before", out_valid, 1);
        check("mid_data_before",  out_data,  8'h61);
        rst_n = 1'b0;
        #1;
        check("mid_valid_rst", out_valid, 0);
        drive(0, 0, 0, 1, 8'h77, 1);
        rst_n = 1'b1;
        #1;
        check("mid_b_ready", b_ready, 1);
        tick();
        check("mid_b_data", out_data, 8'h77);
        check("mid_b_sel",  sel,      1);
        drive(0, 0, 0, 0, 0, 0);

        // ---- counter saturation on the cnt_w=2 instance ----
        do_reset();
        check("sat_start", s_a_count, 0);
        drive(1, 8'h90, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat_a_count%0d", i), s_a_count, exp_sat[i]);
            check($sformatf("wide_a_count%0d", i), a_count, i + 1);
        end
        drive(0, 0, 0, 0, 0, 0);
        check("sat_b_count", s_b_count, 0);
        check("sat_out_data", s_out_data, 8'h90);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
